// File: rtl/seg_scan.sv
// seg_scan: time-multiplexes N active-low digit patterns onto one segment bus with per-slot blanking.
// Define SEG_SCAN_DIM_EN to add a 4-bit duty input that PWM-dims the lit phase.
module seg_scan #(
    parameter int N_DIGITS = 2,
    parameter int DIV      = 1000,
    parameter int BLANK    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
`ifdef SEG_SCAN_DIM_EN
    input  logic [3:0]            duty,
`endif
    input  logic [8*N_DIGITS-1:0] seg_in,
    output logic [7:0]            seg_out,
    output logic [N_DIGITS-1:0]   an_out,
    output logic                  frame_tick
);
    localparam int CW = $clog2(DIV);
    localparam int IW = N_DIGITS > 1 ? $clog2(N_DIGITS) : 1;
    localparam logic [CW-1:0] CNT_MAX   = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK);
    localparam logic [IW-1:0] IDX_MAX   = IW'(N_DIGITS - 1);
    logic [CW-1:0]         cnt;
    logic [IW-1:0]         idx;
    logic [8*N_DIGITS-1:0] snap;
    logic                  frame_start;
    logic                  lit;
    logic [7:0]            seg_nxt;
    logic [N_DIGITS-1:0]   an_nxt;
    assign frame_start = cnt == '0 && idx == '0;
`ifdef SEG_SCAN_DIM_EN
    logic [3:0] pwm;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) pwm <= '0;
        else     pwm <= pwm + 1'b1;
    end
    assign lit = cnt >= CNT_BLANK && pwm < duty;
`else
    assign lit = cnt >= CNT_BLANK;
`endif
    // Both buses go dark together so a blanked digit never shows stale segments.
    always_comb begin
        seg_nxt = lit ? snap[8*idx +: 8] : 8'hFF;
        an_nxt  = lit ? ~(N_DIGITS'(1) << idx) : '1;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            idx        <= '0;
            snap       <= '1;
            seg_out    <= 8'hFF;
            an_out     <= '1;
            frame_tick <= 1'b0;
        end else begin
            cnt        <= cnt == CNT_MAX ? '0 : cnt + 1'b1;
            if (cnt == CNT_MAX) idx <= idx == IDX_MAX ? '0 : idx + 1'b1;
            if (frame_start) snap <= seg_in;
            seg_out    <= seg_nxt;
            an_out     <= an_nxt;
            frame_tick <= frame_start;
        end
    end
endmodule

// File: tb/tb_seg_scan.sv
// tb_seg_scan: scoreboard bench for seg_scan with N_DIGITS=2, DIV=8, BLANK=2.
module tb_seg_scan;
    typedef struct packed {
        logic [7:0] seg;
        logic [1:0] an;
        logic       tick;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] seg_in = 16'hFFFF;
    logic [7:0]  seg_out;
    logic [1:0]  an_out;
    logic        frame_tick;
`ifdef SEG_SCAN_DIM_EN
    logic [3:0]  duty = 4'd15;
    logic [3:0]  duty_hist [0:255];
`endif
    logic [15:0] seg_hist [0:255];
    exp_t        q [$];
    int          t;
    int          checks = 0;
    int          errors = 0;

    seg_scan #(.N_DIGITS(2), .DIV(8), .BLANK(2)) dut (
        .clk(clk),
        .rst(rst),
`ifdef SEG_SCAN_DIM_EN
        .duty(duty),
`endif
        .seg_in(seg_in),
        .seg_out(seg_out),
        .an_out(an_out),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    // Expected outputs in cycle c, from the stimulus history of cycles before c.
    function automatic exp_t exp_at(int c);
        exp_t e;
        int   k;
        int   base;
        logic lit;
        e = '{seg: 8'hFF, an: 2'b11, tick: 1'b0};
        if (c == 0) return e;
        k      = (c - 1) % 16;
        base   = (c - 1) - k;
        e.tick = (k == 0);
        lit    = (k % 8) >= 2;
`ifdef SEG_SCAN_DIM_EN
        lit    = lit && (((c - 1) % 16) < int'(duty_hist[c-1]));
`endif
        if (lit) begin
            e.an  = (k >= 8) ? 2'b01 : 2'b10;
            e.seg = (k >= 8) ? seg_hist[base][15:8] : seg_hist[base][7:0];
        end
        return e;
    endfunction

    task automatic apply_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        t = 0;
        q.delete();
        q.push_back(exp_at(0));
    endtask

    task automatic record();
        seg_hist[t] = seg_in;
`ifdef SEG_SCAN_DIM_EN
        duty_hist[t] = duty;
`endif
        q.push_back(exp_at(t + 1));
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({seg_out, an_out, frame_tick} !== {8'hFF, 2'b11, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: seg_out=%h an_out=%b tick=%b, expected FF 11 0", seg_out, an_out, frame_tick);
        end
    endtask

    task automatic test_first_frame();
        exp_t e;
        seg_in = 16'hA4F9;
        apply_reset();
        for (int i = 0; i < 20; i++) begin
            record();
            e = q.pop_front();
            checks++;
            if ({seg_out, an_out, frame_tick} !== e) begin
                errors++;
                $display("FAIL first_frame cycle %0d: seg_out=%h an_out=%b tick=%b, expected %h %b %b", t, seg_out, an_out, frame_tick, e.seg, e.an, e.tick);
            end
            if (t == 5 || t == 12) begin
                checks++;
                if ({seg_out, an_out} !== (t == 5 ? {8'hF9, 2'b10} : {8'hA4, 2'b01})) begin
                    errors++;
                    $display("FAIL first_frame_spot cycle %0d: seg_out=%h an_out=%b", t, seg_out, an_out);
                end
            end
            @(negedge clk);
            t++;
        end
    endtask

    task automatic test_snapshot();
        exp_t e;
        seg_in = 16'hA4F9;
        apply_reset();
        for (int i = 0; i < 24; i++) begin
            if (t == 5) seg_in = 16'h0000;
            record();
            e = q.pop_front();
            checks++;
            if ({seg_out, an_out, frame_tick} !== e) begin
                errors++;
                $display("FAIL snapshot cycle %0d: seg_out=%h an_out=%b tick=%b, expected %h %b %b", t, seg_out, an_out, frame_tick, e.seg, e.an, e.tick);
            end
            if (t == 14 || t == 19) begin
                checks++;
                if ({seg_out, an_out} !== (t == 14 ? {8'hA4, 2'b01} : {8'h00, 2'b10})) begin
                    errors++;
                    $display("FAIL snapshot_spot cycle %0d: seg_out=%h an_out=%b", t, seg_out, an_out);
                end
            end
            @(negedge clk);
            t++;
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        seg_in = 16'hA4F9;
        apply_reset();
        while (t <= 6) begin
            record();
            e = q.pop_front();
            checks++;
            if ({seg_out, an_out, frame_tick} !== e) begin
                errors++;
                $display("FAIL async_pre cycle %0d: seg_out=%h an_out=%b tick=%b, expected %h %b %b", t, seg_out, an_out, frame_tick, e.seg, e.an, e.tick);
            end
            if (t < 6) begin
                @(negedge clk);
                t++;
            end else begin
                t++;
            end
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({seg_out, an_out, frame_tick} !== {8'hFF, 2'b11, 1'b0}) begin
            errors++;
            $display("FAIL async_dark: seg_out=%h an_out=%b tick=%b, expected FF 11 0", seg_out, an_out, frame_tick);
        end
        apply_reset();
        for (int i = 0; i < 18; i++) begin
            record();
            e = q.pop_front();
            checks++;
            if ({seg_out, an_out, frame_tick} !== e) begin
                errors++;
                $display("FAIL async_restart cycle %0d: seg_out=%h an_out=%b tick=%b, expected %h %b %b", t, seg_out, an_out, frame_tick, e.seg, e.an, e.tick);
            end
            @(negedge clk);
            t++;
        end
    endtask

    task automatic test_random();
        exp_t e;
        int   last_tick = -1;
        apply_reset();
        for (int i = 0; i < 10 * 16 + 2; i++) begin
            seg_in = 16'($urandom);
            record();
            e = q.pop_front();
            checks++;
            if ({seg_out, an_out, frame_tick} !== e) begin
                errors++;
                $display("FAIL random cycle %0d: seg_out=%h an_out=%b tick=%b, expected %h %b %b", t, seg_out, an_out, frame_tick, e.seg, e.an, e.tick);
            end
            checks++;
            if (an_out === 2'b00 || (an_out === 2'b11 && seg_out !== 8'hFF)) begin
                errors++;
                $display("FAIL random_invariant cycle %0d: seg_out=%h an_out=%b", t, seg_out, an_out);
            end
            if (frame_tick === 1'b1) begin
                if (last_tick >= 0) begin
                    checks++;
                    if (t - last_tick != 16) begin
                        errors++;
                        $display("FAIL tick_period cycle %0d: period=%0d expected 16", t, t - last_tick);
                    end
                end
                last_tick = t;
            end
            @(negedge clk);
            t++;
        end
    endtask

`ifdef SEG_SCAN_DIM_EN
    task automatic test_dim();
        exp_t e;
        seg_in = 16'h1234;
        duty = 4'd0;
        apply_reset();
        for (int i = 0; i < 34; i++) begin
            record();
            e = q.pop_front();
            checks++;
            if (an_out !== 2'b11 || seg_out !== 8'hFF) begin
                errors++;
                $display("FAIL dim_zero cycle %0d: seg_out=%h an_out=%b, expected FF 11", t, seg_out, an_out);
            end
            @(negedge clk);
            t++;
        end
        duty = 4'd8;
        apply_reset();
        for (int i = 0; i < 34; i++) begin
            record();
            e = q.pop_front();
            checks++;
            if ({seg_out, an_out, frame_tick} !== e) begin
                errors++;
                $display("FAIL dim_half cycle %0d: seg_out=%h an_out=%b tick=%b, expected %h %b %b", t, seg_out, an_out, frame_tick, e.seg, e.an, e.tick);
            end
            @(negedge clk);
            t++;
        end
        duty = 4'd15;
    endtask
`endif

    initial begin
        test_reset();
        test_first_frame();
        test_snapshot();
        test_async_reset();
        test_random();
`ifdef SEG_SCAN_DIM_EN
        test_dim();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
